// File: rtl/mem_arb_pkg.sv
// Shared encodings and limits for the two-port memory arbiter.
// Optional round-robin tie-break is enabled by defining ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        CPU    = 1'b0,
        LOADER = 1'b1
    } owner_e;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Down-counter load value; out-of-range settings are clamped.
    function automatic logic [3:0] wait_load(input int wc);
        int w;
        w = wc;
        if (w < WAIT_MIN) w = WAIT_MIN;
        if (w > WAIT_MAX) w = WAIT_MAX;
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way tie-break between CPU and loader requests.
// A tie goes to the port that did not own the previous grant.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_ld,
    input  logic last_owner,
    output logic owner
);

    always_comb begin
        owner = CPU;
        if (req_cpu && req_ld) begin
            owner = (last_owner == CPU) ? LOADER : CPU;
        end else if (req_ld) begin
            owner = LOADER;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a multicycle CPU and a loader port.
// Define ARB_RR_EN for round-robin ties; otherwise the CPU always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

    logic cpu_req;
    logic any_req;
    logic last_owner;
    logic pick;

    assign cpu_req = cpu_rd | cpu_wr;
    assign any_req = cpu_req | ld_req;

    rr_pick2 u_pick (
        .req_cpu    (cpu_req),
        .req_ld     (ld_req),
        .last_owner (last_owner),
        .owner      (pick)
    );

`ifdef ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LOADER;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_owner = last_q;
`else
    // Treating the loader as last owner makes every tie go to the CPU.
    assign last_owner = LOADER;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    owner_d = owner_e'(pick);
                    if (owner_e'(pick) == CPU) begin
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        we_d    = cpu_wr;
                    end else begin
                        addr_d  = ld_addr;
                        wdata_d = ld_wdata;
                        we_d    = ld_we;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == CPU) begin
                            cpu_rdata_d = mem_rdata;
                        end else begin
                            ld_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign ld_gnt  = (state_q == ACCESS || state_q == DONE)
                   && (owner_q == LOADER);
    assign ld_done = (state_q == DONE) && (owner_q == LOADER);

    // Released only in DONE so the CPU advances exactly once per access.
    assign cpu_stall = cpu_req
                     && !((state_q == DONE) && (owner_q == CPU));

    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with WAIT_CYCLES=2.
// Round-robin expectations apply when ARB_RR_EN is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic        ld_gnt, ld_done;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk;
    int n_fail;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_done   (ld_done),
        .ld_rdata  (ld_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic [31:0] mrd;
        logic        x_stall;
        logic        x_en;
        logic        x_we;
        logic        x_gnt;
        logic        x_done;
        logic [31:0] x_maddr;
        logic [31:0] x_mwdata;
        logic [31:0] x_crd;
        logic [31:0] x_lrd;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ld_req    = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_wdata  = '0;
        mem_rdata = '0;
    endtask

    initial begin
        logic exp_own [3];
        logic got_own [3];
        int   got_cyc [3];
        int   ng;
        logic prev_en;
        string nm;

        n_chk  = 0;
        n_fail = 0;

        // CPU read 0x10
        vecs[0]  = '{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'h0,32'h0};
        vecs[1]  = '{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b1,1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0, 32'h0,32'h0};
        vecs[2]  = '{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF,
                     1'b1,1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0, 32'h0,32'h0};
        vecs[3]  = '{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[4]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        // Loader write 0x20 <- 0x12345678
        vecs[5]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[6]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'h0,
                     1'b0,1'b1,1'b1,1'b1,1'b0, 32'h20,32'h12345678, 32'hDEADBEEF,32'h0};
        vecs[7]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'h99999999,
                     1'b0,1'b1,1'b1,1'b1,1'b0, 32'h20,32'h12345678, 32'hDEADBEEF,32'h0};
        vecs[8]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[9]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        // rd and wr together at 0x30: a write
        vecs[10] = '{1'b1,1'b1,32'h30,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[11] = '{1'b1,1'b1,32'h30,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b1,1'b1,1'b1,1'b0,1'b0, 32'h30,32'hA5A5A5A5, 32'hDEADBEEF,32'h0};
        vecs[12] = '{1'b1,1'b1,32'h30,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0, 32'h11111111,
                     1'b1,1'b1,1'b1,1'b0,1'b0, 32'h30,32'hA5A5A5A5, 32'hDEADBEEF,32'h0};
        vecs[13] = '{1'b1,1'b1,32'h30,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[14] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        // Loader read 0x40, request dropped after one cycle
        vecs[15] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h40,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'h0};
        vecs[16] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b1,1'b0,1'b1,1'b0, 32'h40,32'h0, 32'hDEADBEEF,32'h0};
        vecs[17] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hCAFEF00D,
                     1'b0,1'b1,1'b0,1'b1,1'b0, 32'h40,32'h0, 32'hDEADBEEF,32'h0};
        vecs[18] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0, 32'hDEADBEEF,32'hCAFEF00D};
        vecs[19] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0, 32'hDEADBEEF,32'hCAFEF00D};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_ld_gnt", ld_gnt, 1'b0);
        chk("rst_ld_done", ld_done, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        cpu_rd = 1'b1;
        #1;
        chk("rst_stall_follows_rd", cpu_stall, 1'b1);
        cpu_rd = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cpu_rd    = vecs[i].rd;
            cpu_wr    = vecs[i].wr;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            ld_req    = vecs[i].lreq;
            ld_we     = vecs[i].lwe;
            ld_addr   = vecs[i].laddr;
            ld_wdata  = vecs[i].lwdata;
            mem_rdata = vecs[i].mrd;
            @(negedge clk);
            nm = $sformatf("v%0d", i);
            chk({nm, "_stall"}, cpu_stall, vecs[i].x_stall);
            chk({nm, "_mem_en"}, mem_en, vecs[i].x_en);
            chk({nm, "_mem_we"}, mem_we, vecs[i].x_we);
            chk({nm, "_ld_gnt"}, ld_gnt, vecs[i].x_gnt);
            chk({nm, "_ld_done"}, ld_done, vecs[i].x_done);
            chk({nm, "_cpu_rdata"}, cpu_rdata, vecs[i].x_crd);
            chk({nm, "_ld_rdata"}, ld_rdata, vecs[i].x_lrd);
            if (vecs[i].x_en) begin
                chk({nm, "_mem_addr"}, mem_addr, vecs[i].x_maddr);
                chk({nm, "_mem_wdata"}, mem_wdata, vecs[i].x_mwdata);
            end
            @(posedge clk);
            #1;
        end

        // Reset pulsed in the first ACCESS cycle of a CPU read
        idle_inputs();
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h50;
        mem_rdata = 32'h77777777;
        @(posedge clk);
        #1;
        chk("rstacc_mem_en_before", mem_en, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstacc_mem_en", mem_en, 1'b0);
        chk("rstacc_cpu_rdata", cpu_rdata, 32'h0);
        chk("rstacc_ld_rdata", ld_rdata, 32'h0);
        chk("rstacc_stall", cpu_stall, 1'b1);
        cpu_rd = 1'b0;
        #1;
        chk("rstacc_stall_low", cpu_stall, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstacc_idle_en", mem_en, 1'b0);
        chk("rstacc_idle_rdata", cpu_rdata, 32'h0);

        // Both ports request continuously from a fresh reset
`ifdef ARB_RR_EN
        exp_own[0] = 1'b0;
        exp_own[1] = 1'b1;
        exp_own[2] = 1'b0;
`else
        exp_own[0] = 1'b0;
        exp_own[1] = 1'b0;
        exp_own[2] = 1'b0;
`endif
        @(posedge clk);
        #1;
        cpu_rd   = 1'b1;
        cpu_addr = 32'h60;
        ld_req   = 1'b1;
        ld_addr  = 32'h70;
        ng       = 0;
        prev_en  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_en && !prev_en && ng < 3) begin
                got_own[ng] = ld_gnt;
                got_cyc[ng] = c;
                ng++;
            end
            prev_en = mem_en;
            if (ng == 3) break;
        end
        chk("arb_grant_count", 32'(ng), 32'd3);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("arb_owner%0d", g), got_own[g], exp_own[g]);
            if (g > 0) begin
                chk($sformatf("arb_gap%0d", g),
                    32'(got_cyc[g] - got_cyc[g-1]), 32'd4);
            end
        end
        idle_inputs();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("arb_quiet_en", mem_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter WAIT_CYCLES, default 1, SHALL set the memory access cycles; the legal range is 1..15.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 cpu_rd, cpu_wr  in  1 each  SHALL be the multicycle datapath read and write strobes.
REQ-007 cpu_addr, cpu_wdata  in  ADDR_W, DATA_W  SHALL be the CPU address and write data.
REQ-008 cpu_rdata  out  DATA_W  SHALL carry the registered CPU read data.
REQ-009 cpu_stall  out  1  SHALL freeze the control FSM while a CPU access is pending.
REQ-010 ld_req, ld_we  in  1 each  SHALL be the loader/debug port request and write-enable.
REQ-011 ld_addr, ld_wdata  in  ADDR_W, DATA_W  SHALL be the loader address and write data.
REQ-012 ld_gnt, ld_done  out  1 each  SHALL be the loader ownership flag and completion pulse.
REQ-013 ld_rdata  out  DATA_W  SHALL carry the registered loader read data.
REQ-014 mem_en, mem_we  out  1 each  SHALL be the single-port memory enable and write strobe.
REQ-015 mem_addr, mem_wdata  out  ADDR_W, DATA_W  SHALL be the memory address and write data.
REQ-016 mem_rdata  in  DATA_W  SHALL be the memory read data, valid on the last ACCESS cycle.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 IDLE SHALL move to ACCESS when either port requests (cpu_rd|cpu_wr, or ld_req), and SHALL then latch the owner, address, write data and write flag.
REQ-019 ACCESS SHALL drive mem_en=1, with mem_we and mem_addr/mem_wdata taken from the latched values, for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-020 On the last ACCESS cycle of a read, mem_rdata SHALL be captured into the owner's rdata register; a write SHALL leave both rdata registers unchanged.
REQ-021 DONE SHALL last one cycle with mem_en=0, and SHALL then return to IDLE.
REQ-022 There SHALL be no back-to-back grants: IDLE is always visited between transactions.
REQ-023 cpu_stall SHALL be combinational: 1 when (cpu_rd|cpu_wr) and the state is not DONE with CPU as owner.
REQ-024 Idle-arbiter CPU latency SHALL be WAIT_CYCLES+2 cycles, with stall high for WAIT_CYCLES+1 cycles.
REQ-025 ld_gnt SHALL be 1 in ACCESS and DONE when the loader is owner; ld_done SHALL pulse for one cycle in DONE.
REQ-026 cpu_rdata and ld_rdata SHALL hold their values until the next read by the same owner completes.
REQ-027 If cpu_rd and cpu_wr are both 1, the arbiter SHALL perform a write.
REQ-028 A requester dropping its request during ACCESS SHALL NOT abort the transaction; the access SHALL complete.
REQ-029 A request that is still asserted in DONE SHALL be treated as a new request when the FSM reaches IDLE.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately and SHALL clear the counter, latches, cpu_rdata and ld_rdata.
REQ-031 During reset, mem_en, mem_we, ld_gnt and ld_done SHALL be 0, and cpu_stall SHALL follow REQ-023.
REQ-032 Reset during ACCESS SHALL abandon the access with no rdata update; last_owner SHALL reset to LOADER.

Configuration
REQ-033 With ARB_RR_EN defined, a simultaneous request in IDLE SHALL be granted to the port that is not last_owner, which SHALL be updated on every grant.
REQ-034 Without ARB_RR_EN, the CPU SHALL always win a tie and the last_owner register SHALL be absent.

Structure
REQ-035 The state encodings (IDLE/ACCESS/DONE), the owner encodings (CPU/LOADER) and WAIT_CYCLES limits SHALL live in shared package mem_arb_pkg.
REQ-036 The two-way tie-break SHALL be a sub-module, rr_pick2, with inputs req_cpu, req_ld and last_owner and output owner.

Verification (WAIT_CYCLES=2)
REQ-037 CPU read 0x10, mem=0xDEADBEEF -> stall high cycles 0-2, cpu_rdata=0xDEADBEEF in cycle 3, mem_en high in cycles 1-2 only.
REQ-038 Loader write 0x20<-0x12345678 -> mem_we high in cycles 1-2, ld_done pulse in cycle 3, cpu_rdata unchanged.
REQ-039 With ARB_RR_EN, both ports request continuously from reset -> grants alternate CPU, LOADER, CPU; without ARB_RR_EN, CPU is granted every time.
REQ-040 cpu_rd and cpu_wr both 1 at 0x30 with wdata 0xA5A5A5A5 -> mem_we=1 and no rdata update.
REQ-041 rst_n pulsed low in cycle 1 of ACCESS -> mem_en=0 at once, state IDLE, cpu_rdata=0.
REQ-042 Loader drops ld_req in cycle 1 -> access still completes and ld_done pulses in cycle 3.
